// File: rtl/muxpri_demux.sv
// muxpri_demux: registered priority demultiplexer.
// Routes one valid/ready input stream to the lowest-index selected output
// channel. Each channel has a one-entry holding register. Beats with no select
// bit set are consumed, flagged on miss and counted in a saturating counter.
//
// Handshake semantics (all ports): a beat transfers on a rising clk edge where
// valid & ready are both high; valid never waits on ready, ready may depend on
// the downstream ready of the target channel (same-cycle pass-through), and a
// producer holds payload/sel stable while valid & ~ready.
module muxpri_demux #(
  parameter int DW = 64,
  parameter int N  = 2,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [N-1:0]    sel,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            miss,
  output logic [CW-1:0]   drop_cnt
);

  localparam logic [N-1:0]  SEL_ONE = N'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [N-1:0]    valid_q, valid_d;
  logic [N*DW-1:0] data_q,  data_d;
  logic            miss_q,  miss_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic [N-1:0]    target_oh;   // one-hot lowest set bit of sel
  logic            none_sel;
  logic [N-1:0]    chan_free;   // channel can take a beat this cycle
  logic [N-1:0]    push;
  logic            drop;

  // Target decode, input readiness and push/drop qualification.
  always_comb begin
    target_oh = sel & (~sel + SEL_ONE);
    none_sel  = (sel == '0);
    chan_free = ~valid_q | out_ready;
    // Only the target channel decides readiness; lower-priority channels
    // never absorb a beat the target cannot take.
    in_ready  = none_sel | (|(target_oh & chan_free));
    push      = target_oh & {N{in_valid & in_ready}};
    drop      = in_valid & none_sel;
  end

  // Next-state for holding registers, miss pulse and drop counter.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        // Push wins over a concurrent pop: the new beat loads with no bubble.
        valid_d[i]          = 1'b1;
        data_d[i*DW +: DW]  = in_data;
      end else if (valid_q[i] && out_ready[i]) begin
        // Pop clears valid; payload keeps its last value.
        valid_d[i] = 1'b0;
      end
    end
    miss_d = drop;
    cnt_d  = cnt_q;
    if (drop && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous active-low reset overriding all updates.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid_q <= '0;
      data_q  <= '0;
      miss_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign miss      = miss_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_muxpri_demux.sv
// Testbench for muxpri_demux with N=2, DW=8, CW=3 (drop counter saturates at 7).
module tb_muxpri_demux;

  localparam int DW = 8;
  localparam int N  = 2;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            nreset;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [N-1:0]    sel;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*DW-1:0] out_data;
  logic            miss;
  logic [CW-1:0]   drop_cnt;

  muxpri_demux #(.DW(DW), .N(N), .CW(CW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .miss      (miss),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [N-1:0] s, input logic [DW-1:0] d,
                       input logic [N-1:0] r);
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            v;
    logic [N-1:0]    s;
    logic [DW-1:0]   d;
    logic [N-1:0]    r;
    logic            e_rdy;
    logic [N-1:0]    e_ov;
    logic [N*DW-1:0] e_od;
    logic            e_miss;
    logic [CW-1:0]   e_cnt;
  } vec_t;

  vec_t vecs[11];
  logic [CW-1:0] cnt_m;
  logic [N-1:0]  s_b;
  int            ch;

  initial begin
    //            v    sel    data   ordy  rdy   ov     od          miss  cnt
    vecs[0]  = '{1'b1, 2'b10, 8'hA5, 2'b11, 1'b1, 2'b10, 16'hA5_00, 1'b0, 3'd0}; // route to ch1
    vecs[1]  = '{1'b1, 2'b11, 8'h3C, 2'b11, 1'b1, 2'b01, 16'hA5_3C, 1'b0, 3'd0}; // priority ch0, ch1 pops
    vecs[2]  = '{1'b1, 2'b01, 8'h11, 2'b00, 1'b0, 2'b01, 16'hA5_3C, 1'b0, 3'd0}; // ch0 full: stall
    vecs[3]  = '{1'b1, 2'b11, 8'h11, 2'b00, 1'b0, 2'b01, 16'hA5_3C, 1'b0, 3'd0}; // no fall-through to ch1
    vecs[4]  = '{1'b1, 2'b01, 8'h11, 2'b01, 1'b1, 2'b01, 16'hA5_11, 1'b0, 3'd0}; // pass-through, no bubble
    vecs[5]  = '{1'b0, 2'b00, 8'h00, 2'b00, 1'b1, 2'b01, 16'hA5_11, 1'b0, 3'd0}; // idle, none -> ready
    vecs[6]  = '{1'b1, 2'b00, 8'h77, 2'b00, 1'b1, 2'b01, 16'hA5_11, 1'b1, 3'd1}; // drop
    vecs[7]  = '{1'b1, 2'b10, 8'h22, 2'b00, 1'b1, 2'b11, 16'h22_11, 1'b0, 3'd1}; // ch1 load, miss clears
    vecs[8]  = '{1'b0, 2'b01, 8'h00, 2'b10, 1'b0, 2'b01, 16'h22_11, 1'b0, 3'd1}; // pop ch1 only
    vecs[9]  = '{1'b0, 2'b10, 8'h00, 2'b11, 1'b1, 2'b00, 16'h22_11, 1'b0, 3'd1}; // pop ch0, data held
    vecs[10] = '{1'b0, 2'b00, 8'h00, 2'b11, 1'b1, 2'b00, 16'h22_11, 1'b0, 3'd1}; // ready on empty: no effect

    // reset
    nreset = 1'b0;
    drive(1'b1, 2'b01, 8'hFF, 2'b00);
    tick();
    tick();
    chk("rst_ov",   32'(out_valid), 32'h0);
    chk("rst_od",   32'(out_data),  32'h0);
    chk("rst_miss", 32'(miss),      32'h0);
    chk("rst_cnt",  32'(drop_cnt),  32'h0);
    nreset = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r);
      chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      tick();
      chk($sformatf("v%0d_ov", i),   32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_od", i),   32'(out_data),  32'(vecs[i].e_od));
      chk($sformatf("v%0d_miss", i), 32'(miss),      32'(vecs[i].e_miss));
      chk($sformatf("v%0d_cnt", i),  32'(drop_cnt),  32'(vecs[i].e_cnt));
    end

    // drop saturation: back-to-back drops from count 1, saturating at 7
    cnt_m = 3'd1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b00, 8'(k), 2'b00);
      chk("drop_rdy", 32'(in_ready), 32'h1);
      tick();
      if (cnt_m != 3'd7) cnt_m = cnt_m + 3'd1;
      chk("drop_miss", 32'(miss),     32'h1);
      chk("drop_cnt",  32'(drop_cnt), 32'(cnt_m));
    end
    drive(1'b0, 2'b00, 8'h00, 2'b00);
    tick();
    chk("drop_miss_clr", 32'(miss),     32'h0);
    chk("drop_cnt_sat",  32'(drop_cnt), 32'h7);

    // back-to-back streaming, alternating channels
    for (int b = 0; b < 16; b++) begin
      s_b = (b % 2 == 0) ? 2'b01 : 2'b10;
      ch  = b % 2;
      drive(1'b1, s_b, 8'(b), 2'b11);
      chk("strm_rdy", 32'(in_ready), 32'h1);
      exp_q.push_back(8'(b));
      tick();
      chk("strm_ov", 32'(out_valid), 32'(s_b));
      if (exp_q.size() > 0)
        chk("strm_od", 32'(out_data[ch*DW +: DW]), 32'(exp_q.pop_front()));
    end
    drive(1'b0, 2'b00, 8'h00, 2'b11);
    tick();
    chk("strm_drain", 32'(out_valid), 32'h0);

    // reset mid-operation: clear, 5 drops, fill both channels, reset with a beat
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b00, 8'h00, 2'b00);
      tick();
    end
    drive(1'b1, 2'b01, 8'h5A, 2'b00);
    tick();
    drive(1'b1, 2'b10, 8'hC3, 2'b00);
    tick();
    chk("pre_rst_ov",  32'(out_valid), 32'h3);
    chk("pre_rst_od",  32'(out_data),  32'hC35A);
    chk("pre_rst_cnt", 32'(drop_cnt),  32'h5);
    nreset = 1'b0;
    drive(1'b1, 2'b01, 8'hEE, 2'b00);
    tick();
    chk("mid_rst_ov",   32'(out_valid), 32'h0);
    chk("mid_rst_od",   32'(out_data),  32'h0);
    chk("mid_rst_miss", 32'(miss),      32'h0);
    chk("mid_rst_cnt",  32'(drop_cnt),  32'h0);
    nreset = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 2'b00);
    tick();
    chk("post_rst_ov", 32'(out_valid), 32'h0);
    chk("post_rst_od", 32'(out_data),  32'h0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muxpri_demux.md
Name: muxpri_demux

Overview:
- Registered priority demultiplexer: the distribution-side counterpart of the priority mux.
- It routes one valid/ready input stream to exactly one of N output channels. The target is the lowest-index asserted bit of sel.
- Each output channel has a one-entry holding register with its own valid/ready handshake.
- Beats presented with no select bit set are dropped and counted.

Parameters:
- DW, 64, data width per channel in bits
- N, 2, number of output channels (N >= 1)
- CW, 8, width of the saturating drop counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- nreset  input  1  synchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  DW  input beat payload
- sel  input  N  channel select, bit 0 highest priority; sampled with the beat
- out_valid  output  N  per-channel holding register valid
- out_ready  input  N  per-channel downstream ready
- out_data  output  N*DW  concatenated channel payloads, channel i at [i*DW +: DW]
- miss  output  1  registered one-cycle pulse, set the cycle after a beat is dropped
- drop_cnt  output  CW  saturating count of dropped beats

Behaviour:
- Reset (nreset low at a clk edge):
  - out_valid=0, out_data=0, miss=0, drop_cnt=0.
  - Reset overrides any concurrent push or pop; beats held at reset are discarded.
- Target select (combinational): t = lowest index i with sel[i]=1. none = (sel==0).
- in_ready (combinational, no dependence on in_valid):
  - none -> 1.
  - otherwise -> ~out_valid[t] | out_ready[t].
  - Pass-through readiness is allowed within the same cycle.
- Strict priority:
  - A beat never falls through to a lower-priority channel when t is full.
  - The input stalls instead.
  - Other set sel bits are ignored.
- Push: when in_valid & in_ready & ~none:
  - out_data[t] <= in_data, out_valid[t] <= 1 at the next edge.
  - Latency is 1 cycle from acceptance to out_valid.
- Pop: when out_valid[i] & out_ready[i], and channel i is not pushed in the same cycle: out_valid[i] <= 0. out_data[i] holds its last value.
- Simultaneous pop and push on the same channel: the new beat loads, out_valid stays 1, no bubble.
- Channels are independent:
  - Pops on non-target channels proceed regardless of input activity.
  - out_ready on an empty channel has no effect.
- Drop: when in_valid & none:
  - The beat is consumed (in_ready=1).
  - miss <= 1 at the next edge; otherwise miss <= 0.
  - drop_cnt increments by 1 and saturates at 2^CW-1, with no wrap.
- sel and in_data must stay stable while in_valid & ~in_ready.
  - If sel changes during a stall, the beat is routed by the sel value present in the cycle it is accepted.
- Holding registers never overwrite unpopped data. No beat is lost except by the explicit drop path.
- N=1: degenerates to a single pipeline register plus the drop path.

Test Plan:
- Basic route: N=2, DW=8.
  - sel=2'b10, in_data=8'hA5, both out_ready=1 -> out_valid=2'b10, out_data[15:8]=8'hA5 one cycle later.
  - Channel 0 untouched.
- Priority: sel=2'b11, in_data=8'h3C -> only channel 0 gets 8'h3C; out_valid=2'b01.
- Stall and pass-through:
  - Channel 0 full, out_ready[0]=0, sel=2'b01 -> in_ready=0; data is held and channel 1 is not loaded.
  - Raise out_ready[0] -> in_ready=1 the same cycle. Next cycle out_data[7:0]=new beat, out_valid[0] stays 1.
- Drop and saturation:
  - CW=2, four beats with sel=0 -> in_ready=1 each cycle, miss pulses 1 cycle after each, drop_cnt=1,2,3,3.
- Back-to-back streaming:
  - 16 consecutive beats 0..15, alternating sel 01/10, out_ready=1 -> every beat appears in order on its channel with 1-cycle latency, in_ready never deasserts.
- Reset mid-operation:
  - Both channels valid, drop_cnt=5, nreset low for one edge with in_valid=1 -> out_valid=0, out_data=0, drop_cnt=0, miss=0.
  - The beat presented during reset is not loaded.
